// File: rtl/iob_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller.
// FWFT output-stage state encodings live here.
package iob_fifo_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

endpackage

// File: rtl/iob_fifo_ptr.sv
// Wrapping W-bit pointer with increment enable.
// Async active-low reset to zero.
module iob_fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;
  assign ptr_o = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/iob_fifo_ram_ctrl.sv
// FIFO controller for an external dual-port byte-enable RAM.
// Define IOB_FIFO_FWFT_EN for first-word-fall-through output.
module iob_fifo_ram_ctrl
  import iob_fifo_pkg::*;
#(
  parameter int NUM_COL = 2,
  parameter int COL_W   = 4,
  parameter int DATA_W  = NUM_COL * COL_W,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic [NUM_COL-1:0] ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic              w_acc;
  logic              pop;
  logic              rd_inc;

  assign w_full = level_q == FULL_LVL;
  assign level  = level_q;
  // Gating with rst_n keeps RAM strobes quiet while reset is held
  assign w_acc  = rst_n & w_en & ~w_full;

  assign ext_mem_w_en   = {NUM_COL{w_acc}};
  assign ext_mem_w_addr = wptr;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_addr = rptr;

  iob_fifo_ptr #(.W(ADDR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_acc),
    .ptr_o (wptr)
  );

  iob_fifo_ptr #(.W(ADDR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rd_inc),
    .ptr_o (rptr)
  );

  always_comb begin
    level_d = level_q;
    case ({w_acc, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

`ifdef IOB_FIFO_FWFT_EN

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] head_q;
  logic [ADDR_W:0]   unfetched;
  logic              fetch;

  // level includes the head word once its fetch has started
  assign unfetched = level_q - {{ADDR_W{1'b0}}, state_q != EMPTY};
  assign pop       = rst_n & r_en & (state_q == VALID);
  assign fetch     = rst_n & (unfetched != '0)
                   & ((state_q == EMPTY) | pop);

  assign rd_inc       = fetch;
  assign ext_mem_r_en = fetch;
  assign r_empty      = state_q != VALID;
  assign r_data       = head_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (fetch) state_d = FETCH;
      FETCH:   state_d = VALID;
      VALID:   if (pop) state_d = fetch ? FETCH : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) head_q <= ext_mem_r_data;
    end
  end

`else

  logic              rd_pend_q;
  logic [DATA_W-1:0] hold_q;

  assign r_empty      = level_q == '0;
  assign pop          = rst_n & r_en & ~r_empty;
  assign rd_inc       = pop;
  assign ext_mem_r_en = pop;
  // RAM output is live only the cycle after a read; hold it afterwards
  assign r_data       = rd_pend_q ? ext_mem_r_data : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= pop;
      if (rd_pend_q) hold_q <= ext_mem_r_data;
    end
  end

`endif

endmodule

// File: tb/tb_iob_fifo_ram_ctrl.sv
// Self-checking bench for iob_fifo_ram_ctrl with a queue model.
// Build with IOB_FIFO_FWFT_EN to exercise the FWFT variant.
module tb_iob_fifo_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en;
  logic [7:0] w_data;
  logic       w_full;
  logic       r_en;
  logic [7:0] r_data;
  logic       r_empty;
  logic [4:0] level;
  logic [1:0] ext_mem_w_en;
  logic [3:0] ext_mem_w_addr;
  logic [7:0] ext_mem_w_data;
  logic       ext_mem_r_en;
  logic [3:0] ext_mem_r_addr;
  logic [7:0] ext_mem_r_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_fifo_ram_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_en           (w_en),
    .w_data         (w_data),
    .w_full         (w_full),
    .r_en           (r_en),
    .r_data         (r_data),
    .r_empty        (r_empty),
    .level          (level),
    .ext_mem_w_en   (ext_mem_w_en),
    .ext_mem_w_addr (ext_mem_w_addr),
    .ext_mem_w_data (ext_mem_w_data),
    .ext_mem_r_en   (ext_mem_r_en),
    .ext_mem_r_addr (ext_mem_r_addr),
    .ext_mem_r_data (ext_mem_r_data)
  );

  // External RAM: column write enables, registered read port
  logic [7:0] mem [16];
  initial ext_mem_r_data = 8'h00;
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (ext_mem_w_en[c])
        mem[ext_mem_w_addr][c*4 +: 4] <= ext_mem_w_data[c*4 +: 4];
    if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic do_reset_check();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(r_empty), 1);
    chk("rst_full", 32'(w_full), 0);
    chk("rst_wen", 32'(ext_mem_w_en), 0);
    chk("rst_ren", 32'(ext_mem_r_en), 0);
  endtask

`ifndef IOB_FIFO_FWFT_EN

  // Reference model: queue of stored words plus accepted-op counts
  logic [7:0] m_q[$];
  int unsigned wcnt = 0;
  int unsigned rcnt = 0;
  logic [7:0] exp_r;
  bit rvalid = 0;
  int seen_aa = 0;

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit wa, ra;
    w_en = w; w_data = d; r_en = r;
    #1;
    wa = w && (m_q.size() < 16);
    ra = r && (m_q.size() > 0);
    chk("w_en_out", 32'(ext_mem_w_en), wa ? 32'h3 : 32'h0);
    if (wa) begin
      chk("w_addr", 32'(ext_mem_w_addr), wcnt % 16);
      chk("w_data_out", 32'(ext_mem_w_data), 32'(d));
    end
    chk("r_en_out", 32'(ext_mem_r_en), 32'(ra));
    if (ra) chk("r_addr", 32'(ext_mem_r_addr), rcnt % 16);
    @(posedge clk);
    if (ra) begin
      exp_r = m_q.pop_front();
      rvalid = 1;
      rcnt++;
    end
    if (wa) begin
      m_q.push_back(d);
      wcnt++;
    end
    #1;
    chk("level", 32'(level), m_q.size());
    chk("full", 32'(w_full), 32'(m_q.size() == 16));
    chk("empty", 32'(r_empty), 32'(m_q.size() == 0));
    if (rvalid) chk("r_data", 32'(r_data), 32'(exp_r));
    if (ra && r_data == 8'hAA) seen_aa++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; w_en = 0; r_en = 0; w_data = 0;
    #7;
    do_reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      step(1, (i == 15) ? 8'h10 : 8'(8'h11 + i), 0);
    chk("full_after16", 32'(w_full), 1);
    chk("level16", 32'(level), 16);

    step(1, 8'hAA, 0);
    chk("no_write_full", 32'(ext_mem_w_en), 0);
    chk("level_stays16", 32'(level), 16);

    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1);
      chk("pop_seq", 32'(r_data), (i == 15) ? 32'h10 : 32'(8'h11 + i));
    end
    chk("no_aa", 32'(seen_aa), 0);
    chk("empty_after16", 32'(r_empty), 1);
    chk("level0", 32'(level), 0);
    step(0, 8'h00, 1);

    // Simultaneous write/pop across the pointer wrap at level 5
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 14; i++) begin
      step(1, 8'(8'h40 + i), 1);
      chk("wrap_level5", 32'(level), 5);
    end
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1);

    // Write and pop at level 0 performs only the write
    step(1, 8'h77, 1);
    chk("wp_at0", 32'(level), 1);
    step(0, 8'h00, 1);

    for (int blk = 0; blk < 8; blk++) begin
      int bw;
      int br;
      bw = (blk % 2 == 0) ? 75 : 35;
      br = (blk % 2 == 0) ? 35 : 75;
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 99) < bw, 8'($urandom),
             $urandom_range(0, 99) < br);
    end

    for (int i = 0; i < 40 && m_q.size() != 7; i++)
      step(m_q.size() < 7, 8'($urandom), m_q.size() > 7);
    chk("level7", 32'(level), 7);

    w_en = 1; r_en = 1; #2;
    rst_n = 1'b0;
    #1;
    do_reset_check();
    m_q.delete();
    wcnt = 0; rcnt = 0; rvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    w_en = 0; r_en = 0;

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`else

  logic [7:0] exp_q[$];

  initial begin
    int guard;
    rst_n = 1'b0; w_en = 0; r_en = 0; w_data = 0;
    #7;
    do_reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    w_en = 1; w_data = 8'h5A;
    @(posedge clk); #1;
    w_en = 0;
    chk("fw_lvl1", 32'(level), 1);
    chk("fw_empty_c0", 32'(r_empty), 1);
    @(posedge clk); #1;
    chk("fw_empty_c1", 32'(r_empty), 1);
    @(posedge clk); #1;
    chk("fw_empty_c2", 32'(r_empty), 0);
    chk("fw_data", 32'(r_data), 32'h5A);
    chk("fw_lvl_head", 32'(level), 1);
    @(negedge clk);
    r_en = 1;
    @(posedge clk); #1;
    r_en = 0;
    chk("fw_pop_empty", 32'(r_empty), 1);
    chk("fw_pop_lvl", 32'(level), 0);

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w_en = 1; w_data = 8'(8'h61 + i);
      exp_q.push_back(w_data);
      @(negedge clk);
    end
    w_en = 0;
    chk("fw_lvl6", 32'(level), 6);
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      guard++;
      if (!r_empty) begin
        chk("fw_order", 32'(r_data), 32'(exp_q.pop_front()));
        r_en = 1;
      end else r_en = 0;
      @(negedge clk);
    end
    r_en = 0;
    chk("fw_drained", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("fw_end_empty", 32'(r_empty), 1);
    chk("fw_end_lvl", 32'(level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`endif

endmodule

// File: doc/iob_fifo_ram_ctrl.md
IOB_FIFO_RAM_CTRL -- requirements
Module: iob_fifo_ram_ctrl

Interface
REQ-001 SHALL have parameter NUM_COL, default 2, meaning the byte-enable column count of the attached RAM.
REQ-002 SHALL have parameter COL_W, default 4, meaning the bits per column.
REQ-003 SHALL have parameter DATA_W, default NUM_COL*COL_W, meaning the word width.
REQ-004 SHALL have parameter ADDR_W, default 4, meaning the RAM address width (depth 2**ADDR_W).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port w_en, input, 1 bit: write request.
REQ-008 SHALL have port w_data, input, DATA_W bits: write word.
REQ-009 SHALL have port w_full, output, 1 bit: no free entry.
REQ-010 SHALL have port r_en, input, 1 bit: read/pop request.
REQ-011 SHALL have port r_data, output, DATA_W bits: read word.
REQ-012 SHALL have port r_empty, output, 1 bit: no readable word.
REQ-013 SHALL have port level, output, ADDR_W+1 bits: stored word count.
REQ-014 SHALL have port ext_mem_w_en, output, NUM_COL bits: RAM port-A column write enables.
REQ-015 SHALL have ports ext_mem_w_addr (output, ADDR_W) and ext_mem_w_data (output, DATA_W): RAM port-A address and data.
REQ-016 SHALL have ports ext_mem_r_en (output, 1) and ext_mem_r_addr (output, ADDR_W): RAM port-B enable and address.
REQ-017 SHALL have port ext_mem_r_data, input, DATA_W bits: RAM port-B registered output, valid 1 cycle after ext_mem_r_en.

Function
REQ-018 SHALL accept a write when w_en=1 and w_full=0, driving ext_mem_w_en to all ones, ext_mem_w_addr to wptr and ext_mem_w_data to w_data combinationally, and incrementing wptr at the edge.
REQ-019 SHALL ignore w_en while w_full=1, leaving memory, wptr and level unchanged, even if r_en is asserted in the same cycle.
REQ-020 SHALL let wptr and rptr be ADDR_W bits wide and wrap from 2**ADDR_W-1 to 0.
REQ-021 SHALL update level by +1 on write only, -1 on pop only, and leave it unchanged on simultaneous write and pop.
REQ-022 SHALL drive w_full=1 exactly when level=2**ADDR_W.
REQ-023 SHALL, in standard mode, accept a pop when r_en=1 and r_empty=0, drive ext_mem_r_en=1 with ext_mem_r_addr=rptr, present the word on r_data in the next cycle, and hold r_data until the next accepted pop.
REQ-024 SHALL, in standard mode, drive r_empty=1 exactly when level=0, and ignore r_en while r_empty=1 with ext_mem_r_en=0.
REQ-025 SHALL, on simultaneous write and pop at level 0, perform the write and ignore the pop.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear wptr, rptr and level to 0 and drive w_full=0, r_empty=1, ext_mem_w_en=0 and ext_mem_r_en=0.
REQ-027 SHALL discard all stored and in-flight words on reset mid-operation, without clearing RAM contents.

Configuration
REQ-028 SHALL, with macro IOB_FIFO_FWFT_EN defined, operate first-word-fall-through with a state machine of states EMPTY, FETCH and VALID.
REQ-029 SHALL, in FWFT mode, issue a RAM read (EMPTY->FETCH) whenever the RAM holds an unfetched word and the output is empty or being popped, move FETCH->VALID at the next edge, and move VALID->EMPTY on a pop with no unfetched word.
REQ-030 SHALL, in FWFT mode, drive r_empty=0 only in VALID with r_data showing the head word, and deassert r_empty two cycles after a write into an empty FIFO.
REQ-031 SHALL, in FWFT mode, count the fetched head word in level.
REQ-032 SHALL, without IOB_FIFO_FWFT_EN, provide standard mode only, with no state machine logic.

Structure
REQ-033 SHALL place the state encodings EMPTY=2'd0, FETCH=2'd1 and VALID=2'd2 in shared package iob_fifo_pkg.
REQ-034 SHALL instantiate sub-module iob_fifo_ptr twice, as a wrapping ADDR_W-bit pointer with increment enable and async reset.

Verification
REQ-035 SHALL cover: reset, then write 0x11..0x1F and 0x10 into 16 entries -> w_full=1 after the 16th write, level=16.
REQ-036 SHALL cover: a 17th write with value 0xAA while full -> ext_mem_w_en=0, level stays 16, and a later read sequence returns no 0xAA.
REQ-037 SHALL cover: 16 pops in standard mode -> r_data=0x11,0x12,... each one cycle after its pop, then r_empty=1 and level=0.
REQ-038 SHALL cover: simultaneous write and pop at level 5 across the pointer wrap from 15 to 0 -> level stays 5 and data order is preserved.
REQ-039 SHALL cover: with IOB_FIFO_FWFT_EN, write 0x5A into an empty FIFO -> r_empty falls two cycles later with r_data=0x5A and no r_en.
REQ-040 SHALL cover: pulse rst_n low mid-stream at level 7 -> immediately level=0, r_empty=1 and w_full=0.
